// File: rtl/edge_event_monitor.sv
// Multi-channel edge/transition detector with per-channel event pulse, sticky flag
// and saturating event counter. Events come from comparing din against the previous sample.
module edge_event_monitor #(
  parameter int CH    = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic [CH-1:0]         clr,
  output logic [CH-1:0]         evt,
  output logic [CH-1:0]         sticky,
  output logic [CH*CNT_W-1:0]   cnt,
  output logic                  any_evt
);

  localparam logic [1:0]       MODE_RISE   = 2'b00;
  localparam logic [1:0]       MODE_FALL   = 2'b01;
  localparam logic [1:0]       MODE_CHANGE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [CH-1:0] det;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] smp;
    logic [1:0]       m;
    logic             hv;
    logic             hit;
    logic             evt_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    assign cur = din[i*WIDTH +: WIDTH];
    assign m   = mode[2*i +: 2];

    always_comb begin
      hit = 1'b0;
      case (m)
        MODE_RISE:   hit = ~smp[0] &  cur[0];
        MODE_FALL:   hit =  smp[0] & ~cur[0];
        MODE_CHANGE: hit = (cur != smp);
        default:     hit = 1'b0;
      endcase
    end

    // hv keeps the first sample after reset or after en rises from firing
    assign det[i] = en & hv & hit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        smp      <= '0;
        hv       <= 1'b0;
        evt_q    <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (en) begin
          smp <= cur;
          hv  <= 1'b1;
        end else begin
          hv  <= 1'b0;
        end
        evt_q <= det[i];
        // a detection on the clearing edge survives the clear
        if (clr[i]) begin
          sticky_q <= det[i];
          cnt_q    <= det[i] ? CNT_W'(1) : '0;
        end else if (det[i]) begin
          sticky_q <= 1'b1;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign evt[i]                 = evt_q;
    assign sticky[i]              = sticky_q;
    assign cnt[i*CNT_W +: CNT_W]  = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_evt <= 1'b0;
    else        any_evt <= |det;
  end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench for edge_event_monitor: stimulus pushes expected outputs from a
// behavioural model; an independent monitor pops and compares after every edge.
module tb_edge_event_monitor;
  localparam int CH = 4;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [2*CH-1:0]    mode;
  logic [CH*WIDTH-1:0] din;
  logic [CH-1:0]      clr;
  logic [CH-1:0]      evt;
  logic [CH-1:0]      sticky;
  logic [CH*CNT_W-1:0] cnt;
  logic               any_evt;

  typedef struct packed {
    logic [CH-1:0]       evt;
    logic [CH-1:0]       sticky;
    logic [CH*CNT_W-1:0] cnt;
    logic                any;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int m_prev[CH];
  bit m_hv[CH];
  int m_cnt[CH];
  bit m_st[CH];

  edge_event_monitor #(.CH(CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .clr(clr),
    .evt(evt), .sticky(sticky), .cnt(cnt), .any_evt(any_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_prev[i] = 0; m_hv[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
    end
  endtask

  // Apply one set of inputs for the coming edge and predict what it produces.
  task automatic cyc(input logic en_v, input logic [2*CH-1:0] mode_v,
                     input logic [CH*WIDTH-1:0] din_v, input logic [CH-1:0] clr_v);
    exp_t e;
    logic [CH-1:0] ev;
    @(negedge clk);
    en = en_v; mode = mode_v; din = din_v; clr = clr_v;
    ev = '0;
    e  = '0;
    for (int i = 0; i < CH; i++) begin
      int cur;
      bit hit;
      cur = int'(din_v[i*WIDTH +: WIDTH]);
      case (mode_v[2*i +: 2])
        2'd0:    hit = (m_prev[i] % 2 == 0) && (cur % 2 == 1);
        2'd1:    hit = (m_prev[i] % 2 == 1) && (cur % 2 == 0);
        2'd2:    hit = (cur != m_prev[i]);
        default: hit = 0;
      endcase
      hit = hit && en_v && m_hv[i];
      ev[i] = hit;
      if (clr_v[i]) begin
        m_cnt[i] = hit ? 1 : 0;
        m_st[i]  = hit;
      end else if (hit) begin
        m_st[i] = 1;
        if (m_cnt[i] < CNT_SAT) m_cnt[i]++;
      end
      if (en_v) begin
        m_prev[i] = cur;
        m_hv[i]   = 1;
      end else begin
        m_hv[i] = 0;
      end
      e.sticky[i] = m_st[i];
      e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    e.evt = ev;
    e.any = |ev;
    q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare whenever a prediction exists.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("cycle", 64'({evt, sticky, cnt, any_evt}), 64'(mon_e));
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b1; en = 1'b0; mode = '1; din = 16'hF000; clr = '0;
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs", 64'({evt, sticky, cnt, any_evt}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // din3 held at 1111 through reset release: first edge only primes
    cyc(1, 8'h3F, 16'hF000, 4'b0000);
    @(posedge clk); #2;
    chk("first_edge_evt3", 64'(evt[3]), 64'd0);
    cyc(1, 8'h3F, 16'hF000, 4'b0000);
    cyc(1, 8'h3F, 16'h0000, 4'b0000);
    cyc(1, 8'h3F, 16'hF000, 4'b0000);
    cyc(0, 8'h3F, 16'h0000, 4'b0000);
    cyc(0, 8'h3F, 16'hF000, 4'b0000);
    cyc(0, 8'h3F, 16'h0000, 4'b0000);
    @(posedge clk); #2;
    chk("en_low_cnt3", 64'(cnt[3*CNT_W +: CNT_W]), 64'd1);
    chk("en_low_evt3", 64'(evt[3]), 64'd0);
    cyc(1, 8'h3F, 16'hF000, 4'b0000);

    // ch0 RISE and ch1 CHANGE on the same sequence
    cyc(1, 8'hFF, 16'h0088, 4'b0000);
    cyc(1, 8'hFF, 16'h0088, 4'b0011);
    cyc(1, 8'hF8, 16'h0088, 4'b0000);
    cyc(1, 8'hF8, 16'h0099, 4'b0000);
    cyc(1, 8'hF8, 16'h00BB, 4'b0000);
    cyc(1, 8'hF8, 16'h00FF, 4'b0000);
    cyc(1, 8'hF8, 16'h00DD, 4'b0000);
    @(posedge clk); #2;
    chk("rise_cnt0", 64'(cnt[0 +: CNT_W]), 64'd1);
    chk("rise_sticky0", 64'(sticky[0]), 64'd1);
    chk("change_cnt1", 64'(cnt[CNT_W +: CNT_W]), 64'd4);

    // ch2 FALL saturation, then clear coincident with a fall
    cyc(1, 8'hDF, 16'h00DD, 4'b0100);
    for (int k = 0; k < 600; k++)
      cyc(1, 8'hDF, (k % 2 == 0) ? 16'h01DD : 16'h00DD, 4'b0000);
    @(posedge clk); #2;
    chk("sat_cnt2", 64'(cnt[2*CNT_W +: CNT_W]), 64'd255);
    cyc(1, 8'hDF, 16'h01DD, 4'b0000);
    cyc(1, 8'hDF, 16'h00DD, 4'b0100);
    @(posedge clk); #2;
    chk("clr_fall_cnt2", 64'(cnt[2*CNT_W +: CNT_W]), 64'd1);
    chk("clr_fall_sticky2", 64'(sticky[2]), 64'd1);

    // build cnt0=5 with evt0 high, then reset mid-cycle
    cyc(1, 8'hFC, 16'h00D0, 4'b0001);
    for (int r = 0; r < 5; r++) begin
      cyc(1, 8'hFC, 16'h00D0, 4'b0000);
      cyc(1, 8'hFC, 16'h00D1, 4'b0000);
    end
    @(posedge clk); #2;
    chk("pre_reset_evt0", 64'(evt[0]), 64'd1);
    chk("pre_reset_cnt0", 64'(cnt[0 +: CNT_W]), 64'd5);
    rst_n = 1'b0; en = 1'b0; clr = '0;
    #1 chk("async_reset_outputs", 64'({evt, sticky, cnt, any_evt}), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 50; k++)
      cyc(1, 8'hFF, 16'($urandom), 4'b0000);
    @(posedge clk); #2;
    chk("off_cnt", 64'(cnt), 64'd0);

    for (int k = 0; k < 500; k++)
      cyc(($urandom_range(0, 9) != 0), 8'($urandom), 16'($urandom),
          ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    chk("drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
